// File: rtl/fetch_datapath.sv
// Multicycle fetch datapath: PC, instruction register, memory-data and ALU-out registers,
// plus instruction field decode. Optional fetch counter enabled by FETCH_INSTR_COUNT_EN.
module fetch_datapath #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PC_Write,
  input  logic                  I_or_D,
  input  logic                  IR_Write,
  input  logic                  PC_Src,
  input  logic [DATA_WIDTH-1:0] ALU_Result,
  input  logic [DATA_WIDTH-1:0] Mem_Rd_Data,
  output logic [DATA_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [5:0]            Op,
  output logic [5:0]            Funct,
  output logic [4:0]            Rs,
  output logic [4:0]            Rt,
  output logic [4:0]            Rd,
  output logic [DATA_WIDTH-1:0] Imm_Ext,
  output logic [DATA_WIDTH-1:0] Mem_Data_Reg,
  output logic [DATA_WIDTH-1:0] ALU_Out,
  output logic                  PC_Align_Err
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0]           Instr_Count
`endif
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
  logic                  align_err_q, align_err_d;
  logic [DATA_WIDTH-1:0] pc_src_val;

  // PC_Src=1 selects the ALU result registered on the previous cycle.
  assign pc_src_val = PC_Src ? alu_out_q : ALU_Result;

  always_comb begin
    pc_d        = pc_q;
    align_err_d = align_err_q;
    instr_d     = instr_q;
    mdr_d       = Mem_Rd_Data;
    alu_out_d   = ALU_Result;
    if (PC_Write) begin
      pc_d = {pc_src_val[DATA_WIDTH-1:2], 2'b00};
      if (pc_src_val[1:0] != 2'b00) begin
        align_err_d = 1'b1;
      end
    end
    if (IR_Write) begin
      instr_d = Mem_Rd_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= PC_RESET;
      instr_q     <= '0;
      mdr_q       <= '0;
      alu_out_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      alu_out_q   <= alu_out_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (IR_Write) begin
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign Instr_Count = instr_count_q;
`else
  // Counter omitted in this build.
`endif

  always_comb begin
    Mem_Addr     = I_or_D ? alu_out_q : pc_q;
    PC           = pc_q;
    Instr        = instr_q;
    Mem_Data_Reg = mdr_q;
    ALU_Out      = alu_out_q;
    PC_Align_Err = align_err_q;
    Op           = instr_q[31:26];
    Rs           = instr_q[25:21];
    Rt           = instr_q[20:16];
    Rd           = instr_q[15:11];
    Funct        = instr_q[5:0];
    Imm_Ext      = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};
  end

endmodule
